// File: rtl/mul_add.sv
// Gated add / multiply primitive for the picoMips ALU datapath; result wraps modulo 2^WIDTH.
// Optional build macro MUL_ADD_REG_OUT_EN registers Out (latency 1, async active-low reset).
module mul_add #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             EnA,
  input  logic             EnB,
  input  logic             Mul,
  output logic [WIDTH-1:0] Out
);

  // Two's-complement sum and low product bits are sign-agnostic, so truncation is the whole story.
  function automatic logic signed [WIDTH-1:0] wrap_add(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] s;
    s = x + y;
    return s;
  endfunction

  function automatic logic signed [WIDTH-1:0] wrap_mul(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] p;
    p = x * y;
    return p;
  endfunction

  logic signed [WIDTH-1:0] a_gated;
  logic signed [WIDTH-1:0] b_gated;
  logic signed [WIDTH-1:0] out_d;

  // Ternary gating selects a constant zero, so a disabled operand cannot leak X into Out.
  always_comb begin
    a_gated = EnA ? A : '0;
    b_gated = EnB ? B : '0;
    out_d   = Mul ? wrap_mul(a_gated, b_gated) : wrap_add(a_gated, b_gated);
  end

`ifdef MUL_ADD_REG_OUT_EN
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) out_q <= '0;
    else         out_q <= out_d;
  end

  assign Out = out_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = Clock ^ nReset;
  assign Out = out_d;
`endif

endmodule

// File: tb/tb_mul_add.sv
// Directed bench for mul_add; works for both the combinational and MUL_ADD_REG_OUT_EN builds.
module tb_mul_add;
  localparam int WIDTH = 8;

  logic             Clock = 1'b0;
  logic             nReset = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             EnA = 1'b0;
  logic             EnB = 1'b0;
  logic             Mul = 1'b0;
  logic [WIDTH-1:0] Out;

  int passed = 0;
  int total  = 0;

  mul_add #(.WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .nReset(nReset),
    .A     (A),
    .B     (B),
    .EnA   (EnA),
    .EnB   (EnB),
    .Mul   (Mul),
    .Out   (Out)
  );

  always #5 Clock = ~Clock;

  // Drive one operation and wait until its result is visible on Out.
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ea, input logic eb, input logic m);
    A = a; B = b; EnA = ea; EnB = eb; Mul = m;
`ifdef MUL_ADD_REG_OUT_EN
    @(posedge Clock);
    #1;
`else
    #2;
`endif
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    A = 8'h55; B = 8'h22; EnA = 1'b1; EnB = 1'b1; Mul = 1'b0;
`ifdef MUL_ADD_REG_OUT_EN
    @(posedge Clock);
    #1;
    total++;
    if (Out !== 8'h00) $display("FAIL reset_hold: Out=%h expected=%h", Out, 8'h00);
    else passed++;
    nReset = 1'b1;
    @(posedge Clock);
    #1;
    total++;
    if (Out !== 8'h77) $display("FAIL reset_first_edge: Out=%h expected=%h", Out, 8'h77);
    else passed++;
    // Drop reset away from any edge: Out must clear without a clock.
    #2;
    nReset = 1'b0;
    #1;
    total++;
    if (Out !== 8'h00) $display("FAIL reset_async: Out=%h expected=%h", Out, 8'h00);
    else passed++;
    @(negedge Clock);
    nReset = 1'b1;
    A = 8'h05; B = 8'h03;
    @(posedge Clock);
    #1;
    total++;
    if (Out !== 8'h08) $display("FAIL reset_release_add: Out=%h expected=%h", Out, 8'h08);
    else passed++;
`else
    #2;
    total++;
    if (Out !== 8'h77) $display("FAIL comb_ignores_reset: Out=%h expected=%h", Out, 8'h77);
    else passed++;
    nReset = 1'b1;
    drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    total++;
    if (Out !== 8'h00) $display("FAIL zero_inputs: Out=%h expected=%h", Out, 8'h00);
    else passed++;
`endif
  endtask

  task automatic test_add;
    logic [WIDTH-1:0] exp_tbl [4] = '{8'h08, 8'h03, 8'h05, 8'h00};
    logic [1:0]       en_tbl  [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      drive(8'h05, 8'h03, en_tbl[i][1], en_tbl[i][0], 1'b0);
      total++;
      if (Out !== exp_tbl[i])
        $display("FAIL add_en%b: Out=%h expected=%h", en_tbl[i], Out, exp_tbl[i]);
      else passed++;
    end
  endtask

  task automatic test_add_wrap;
    drive(8'h7F, 8'h01, 1'b1, 1'b1, 1'b0);
    total++;
    if (Out !== 8'h80) $display("FAIL add_wrap_7f: Out=%h expected=%h", Out, 8'h80);
    else passed++;
    drive(8'hFF, 8'h02, 1'b1, 1'b1, 1'b0);
    total++;
    if (Out !== 8'h01) $display("FAIL add_wrap_ff: Out=%h expected=%h", Out, 8'h01);
    else passed++;
  endtask

  task automatic test_mul;
    logic [WIDTH-1:0] a_tbl   [6] = '{8'h01, 8'h00, 8'h10, 8'hFE, 8'h0C, 8'h07};
    logic [WIDTH-1:0] b_tbl   [6] = '{8'hF6, 8'hF6, 8'h10, 8'h03, 8'h0B, 8'h09};
    logic [WIDTH-1:0] exp_tbl [6] = '{8'hF6, 8'h00, 8'h00, 8'hFA, 8'h84, 8'h3F};
    for (int i = 0; i < 6; i++) begin
      drive(a_tbl[i], b_tbl[i], 1'b1, 1'b1, 1'b1);
      total++;
      if (Out !== exp_tbl[i])
        $display("FAIL mul_%h_x_%h: Out=%h expected=%h", a_tbl[i], b_tbl[i], Out, exp_tbl[i]);
      else passed++;
    end
    // Disabled operand forces a zero product.
    drive(8'h0C, 8'h0B, 1'b1, 1'b0, 1'b1);
    total++;
    if (Out !== 8'h00) $display("FAIL mul_enb0: Out=%h expected=%h", Out, 8'h00);
    else passed++;
  endtask

  task automatic test_gating;
    drive('x, 8'h22, 1'b0, 1'b1, 1'b0);
    total++;
    if (Out !== 8'h22) $display("FAIL gate_a_x_add: Out=%h expected=%h", Out, 8'h22);
    else passed++;
    drive(8'h13, 'x, 1'b1, 1'b0, 1'b0);
    total++;
    if (Out !== 8'h13) $display("FAIL gate_b_x_add: Out=%h expected=%h", Out, 8'h13);
    else passed++;
  endtask

  task automatic test_back_to_back;
    // Same operands, mode toggled each step.
    drive(8'h06, 8'h07, 1'b1, 1'b1, 1'b1);
    total++;
    if (Out !== 8'h2A) $display("FAIL b2b_mul: Out=%h expected=%h", Out, 8'h2A);
    else passed++;
    drive(8'h06, 8'h07, 1'b1, 1'b1, 1'b0);
    total++;
    if (Out !== 8'h0D) $display("FAIL b2b_add: Out=%h expected=%h", Out, 8'h0D);
    else passed++;
    drive(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    total++;
    if (Out !== 8'h00) $display("FAIL b2b_add_80: Out=%h expected=%h", Out, 8'h00);
    else passed++;
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    total++;
    if (Out !== 8'h01) $display("FAIL b2b_mul_ff: Out=%h expected=%h", Out, 8'h01);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_mul();
    test_gating();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
